// File: rtl/elevator_pkg.sv
// Shared constants and types for the hall call dispatcher.
package elevator_pkg;
    localparam int NUM_FLOORS  = 11;
    localparam int NUM_LIFTS   = 4;
    localparam int FLOOR_W     = 4;
    localparam int ACK_TIMEOUT = 15;

    typedef enum logic { DIR_DN = 1'b0, DIR_UP = 1'b1 } dir_t;

    typedef enum logic [1:0] {
        LIFT_IDLE = 2'b00,
        LIFT_UP   = 2'b01,
        LIFT_DN   = 2'b10
    } lift_dir_t;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SCAN  = 2'b01,
        EVAL  = 2'b10,
        ISSUE = 2'b11
    } dispatch_state_t;
endpackage

// File: rtl/nearest_lift_select.sv
// Combinational selector: cheapest eligible lift by floor distance, lowest index on ties.
module nearest_lift_select #(
    parameter int NUM_LIFTS = 4,
    parameter int FLOOR_W   = 4
) (
    input  logic [NUM_LIFTS*FLOOR_W-1:0] i_floors,
    input  logic [NUM_LIFTS-1:0]         i_elig,
    input  logic [FLOOR_W-1:0]           i_target,
    output logic [NUM_LIFTS-1:0]         o_pick,
    output logic                         o_found
);
    function automatic logic [FLOOR_W:0] floor_dist(input logic [FLOOR_W-1:0] a,
                                                    input logic [FLOOR_W-1:0] b);
        logic [FLOOR_W:0] d;
        if (a >= b) begin
            d = {1'b0, a} - {1'b0, b};
        end else begin
            d = {1'b0, b} - {1'b0, a};
        end
        return d;
    endfunction

    logic [FLOOR_W:0] w_best;
    logic [FLOOR_W:0] w_cost;

    // Linear scan; strict less-than keeps the lowest index when costs tie.
    always_comb begin
        o_pick  = '0;
        o_found = 1'b0;
        w_best  = '1;
        w_cost  = '0;
        for (int k = 0; k < NUM_LIFTS; k++) begin
            w_cost = floor_dist(i_floors[k*FLOOR_W +: FLOOR_W], i_target);
            if (i_elig[k] && (!o_found || (w_cost < w_best))) begin
                w_best  = w_cost;
                o_pick  = {{(NUM_LIFTS-1){1'b0}}, 1'b1} << k;
                o_found = 1'b1;
            end else begin
                w_best = w_best;
            end
        end
    end
endmodule

// File: rtl/hall_call_dispatcher.sv
// Hall call dispatcher: latches hall calls, picks one round-robin, offers it to the nearest free lift.
// Optional macro DIR_AWARE_EN adds lift_dir and lets busy lifts already heading to the call compete.
module hall_call_dispatcher
    import elevator_pkg::*;
#(
    parameter int NUM_FLOORS  = 11,
    parameter int NUM_LIFTS   = 4,
    parameter int FLOOR_W     = 4,
    parameter int ACK_TIMEOUT = 15
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_FLOORS-1:0]         hall_up_req,
    input  logic [NUM_FLOORS-1:0]         hall_dn_req,
    input  logic [NUM_LIFTS*FLOOR_W-1:0]  lift_floor,
    input  logic [NUM_LIFTS-1:0]          lift_busy,
`ifdef DIR_AWARE_EN
    input  logic [NUM_LIFTS*2-1:0]        lift_dir,
`endif
    output logic [NUM_LIFTS-1:0]          assign_valid,
    output logic [FLOOR_W-1:0]            assign_floor,
    output logic                          assign_dir,
    input  logic [NUM_LIFTS-1:0]          assign_ready,
    output logic [NUM_FLOORS-1:0]         up_pending,
    output logic [NUM_FLOORS-1:0]         dn_pending
);
    localparam int N_ENT   = 2 * NUM_FLOORS;
    localparam int ENTRY_W = $clog2(N_ENT);
    localparam int TMO_W   = $clog2(ACK_TIMEOUT + 1);
    localparam logic [NUM_FLOORS-1:0] UP_OK = {1'b0, {(NUM_FLOORS-1){1'b1}}};
    localparam logic [NUM_FLOORS-1:0] DN_OK = {{(NUM_FLOORS-1){1'b1}}, 1'b0};
    localparam logic [NUM_FLOORS-1:0] ONE_F = {{(NUM_FLOORS-1){1'b0}}, 1'b1};

    dispatch_state_t         r_state, w_state_nxt;
    logic [NUM_FLOORS-1:0]   r_up, r_dn, w_clr_up, w_clr_dn;
    logic [N_ENT-1:0]        w_pend;
    logic [ENTRY_W-1:0]      r_ptr, r_entry, w_scan_entry, w_ptr_nxt;
    logic                    w_scan_found;
    logic [FLOOR_W-1:0]      r_floor, w_scan_floor;
    dir_t                    r_dir, w_scan_dir;
    logic [NUM_LIFTS-1:0]    r_valid, r_skip, w_elig, w_pick;
    logic                    w_pick_found, w_hs, w_timeout;
    logic [TMO_W-1:0]        r_tmo;
    logic [FLOOR_W-1:0]      w_lf [NUM_LIFTS];
`ifdef DIR_AWARE_EN
    lift_dir_t               w_ld;
    logic                    w_same, w_toward;
`endif

    function automatic logic [ENTRY_W-1:0] wrap_add(input logic [ENTRY_W-1:0] p, input int i);
        int s;
        s = int'(p) + i;
        if (s >= N_ENT) begin
            s = s - N_ENT;
        end else begin
            s = s;
        end
        return ENTRY_W'(s);
    endfunction

    assign w_pend    = {r_dn, r_up};
    assign w_hs      = (r_state == ISSUE) && (|(r_valid & assign_ready));
    assign w_timeout = (r_state == ISSUE) && !w_hs && (r_tmo == TMO_W'(ACK_TIMEOUT - 1));
    assign w_ptr_nxt = (r_entry == ENTRY_W'(N_ENT - 1)) ? '0 : r_entry + ENTRY_W'(1);
    assign w_clr_up  = (w_hs && (r_dir == DIR_UP)) ? (ONE_F << r_floor) : '0;
    assign w_clr_dn  = (w_hs && (r_dir == DIR_DN)) ? (ONE_F << r_floor) : '0;

    // First pending entry at or after the scan pointer, wrapping.
    always_comb begin
        w_scan_found = 1'b0;
        w_scan_entry = '0;
        for (int i = 0; i < N_ENT; i++) begin
            if (!w_scan_found && w_pend[wrap_add(r_ptr, i)]) begin
                w_scan_found = 1'b1;
                w_scan_entry = wrap_add(r_ptr, i);
            end else begin
                w_scan_found = w_scan_found;
            end
        end
    end

    // Split a call index into target floor and direction.
    always_comb begin
        if (w_scan_entry < ENTRY_W'(NUM_FLOORS)) begin
            w_scan_floor = FLOOR_W'(w_scan_entry);
            w_scan_dir   = DIR_UP;
        end else begin
            w_scan_floor = FLOOR_W'(w_scan_entry - ENTRY_W'(NUM_FLOORS));
            w_scan_dir   = DIR_DN;
        end
    end

    // Candidate mask: skipped lifts and lifts reporting an out-of-range floor never compete.
    always_comb begin
        w_elig = '0;
`ifdef DIR_AWARE_EN
        w_ld     = LIFT_IDLE;
        w_same   = 1'b0;
        w_toward = 1'b0;
`endif
        for (int k = 0; k < NUM_LIFTS; k++) begin
            w_lf[k] = lift_floor[k*FLOOR_W +: FLOOR_W];
`ifdef DIR_AWARE_EN
            w_ld     = lift_dir_t'(lift_dir[2*k +: 2]);
            w_same   = ((r_dir == DIR_UP) && (w_ld == LIFT_UP)) ||
                       ((r_dir == DIR_DN) && (w_ld == LIFT_DN));
            w_toward = (r_dir == DIR_UP) ? (w_lf[k] < r_floor) : (w_lf[k] > r_floor);
            w_elig[k] = !r_skip[k] && (int'(w_lf[k]) < NUM_FLOORS) &&
                        ((!lift_busy[k] && ((w_ld == LIFT_IDLE) || w_same)) ||
                         (lift_busy[k] && w_same && w_toward));
`else
            w_elig[k] = !lift_busy[k] && !r_skip[k] && (int'(w_lf[k]) < NUM_FLOORS);
`endif
        end
    end

    nearest_lift_select #(
        .NUM_LIFTS (NUM_LIFTS),
        .FLOOR_W   (FLOOR_W)
    ) u_select (
        .i_floors (lift_floor),
        .i_elig   (w_elig),
        .i_target (r_floor),
        .o_pick   (w_pick),
        .o_found  (w_pick_found)
    );

    // Next-state logic.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (|w_pend)      w_state_nxt = SCAN;  else w_state_nxt = IDLE;
            SCAN:    if (w_scan_found) w_state_nxt = EVAL;  else w_state_nxt = IDLE;
            EVAL:    if (w_pick_found) w_state_nxt = ISSUE; else w_state_nxt = EVAL;
            ISSUE:   if (w_hs)         w_state_nxt = IDLE;
                     else if (w_timeout) w_state_nxt = EVAL;
                     else              w_state_nxt = ISSUE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= IDLE;
        else      r_state <= w_state_nxt;
    end

    // Pending calls, latched call, offer, skip mask and ack timer.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_up    <= '0;
            r_dn    <= '0;
            r_ptr   <= '0;
            r_entry <= '0;
            r_floor <= '0;
            r_dir   <= DIR_DN;
            r_valid <= '0;
            r_skip  <= '0;
            r_tmo   <= '0;
        end else begin
            r_up <= (r_up | (hall_up_req & UP_OK)) & ~w_clr_up;
            r_dn <= (r_dn | (hall_dn_req & DN_OK)) & ~w_clr_dn;
            case (r_state)
                SCAN: begin
                    if (w_scan_found) begin
                        r_entry <= w_scan_entry;
                        r_floor <= w_scan_floor;
                        r_dir   <= w_scan_dir;
                    end
                end
                EVAL: begin
                    if (w_pick_found) begin
                        r_valid <= w_pick;
                        r_tmo   <= '0;
                    end else if (r_skip != '0) begin
                        r_skip <= '0;
                    end
                end
                ISSUE: begin
                    if (w_hs) begin
                        r_valid <= '0;
                        r_ptr   <= w_ptr_nxt;
                        r_skip  <= '0;
                    end else if (w_timeout) begin
                        r_valid <= '0;
                        r_skip  <= r_skip | r_valid;
                    end else begin
                        r_tmo <= r_tmo + TMO_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign assign_valid = r_valid;
    assign assign_floor = r_floor;
    assign assign_dir   = r_dir;
    assign up_pending   = r_up;
    assign dn_pending   = r_dn;
endmodule

// File: tb/tb_hall_call_dispatcher.sv
// Directed plus randomized bench for hall_call_dispatcher against a call-list reference model.
module tb_hall_call_dispatcher;
    localparam int NF  = 11;
    localparam int NL  = 4;
    localparam int FW  = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic [NF-1:0]     hall_up_req, hall_dn_req;
    logic [NL*FW-1:0]  lift_floor;
    logic [NL-1:0]     lift_busy;
    logic [NL*2-1:0]   lift_dir;
    logic [NL-1:0]     assign_valid, assign_ready;
    logic [FW-1:0]     assign_floor;
    logic              assign_dir;
    logic [NF-1:0]     up_pending, dn_pending;

    int vectors = 0;
    int miscompares = 0;
    bit m_pend [2*NF];
    int m_ptr = 0;

    hall_call_dispatcher dut (
        .clk          (clk),
        .rst          (rst),
        .hall_up_req  (hall_up_req),
        .hall_dn_req  (hall_dn_req),
        .lift_floor   (lift_floor),
        .lift_busy    (lift_busy),
`ifdef DIR_AWARE_EN
        .lift_dir     (lift_dir),
`endif
        .assign_valid (assign_valid),
        .assign_floor (assign_floor),
        .assign_dir   (assign_dir),
        .assign_ready (assign_ready),
        .up_pending   (up_pending),
        .dn_pending   (dn_pending)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_floors(input int a, input int b, input int c, input int d);
        lift_floor = {FW'(d), FW'(c), FW'(b), FW'(a)};
    endtask

    function automatic void model_clear();
        for (int e = 0; e < 2*NF; e++) m_pend[e] = 1'b0;
        m_ptr = 0;
    endfunction

    function automatic logic [31:0] model_vec();
        logic [31:0] v = '0;
        for (int e = 0; e < 2*NF; e++) v[e] = m_pend[e];
        return v;
    endfunction

    function automatic int model_first();
        for (int i = 0; i < 2*NF; i++) begin
            if (m_pend[(m_ptr + i) % (2*NF)]) return (m_ptr + i) % (2*NF);
        end
        return -1;
    endfunction

    function automatic int model_lift(input int target);
        int best = -1;
        int bc = 1000;
        for (int k = 0; k < NL; k++) begin
            int fl = int'(lift_floor[k*FW +: FW]);
            int c = (fl > target) ? fl - target : target - fl;
            if (!lift_busy[k] && fl < NF && c < bc) begin
                bc = c;
                best = k;
            end
        end
        return best;
    endfunction

    task automatic pulse(input logic [NF-1:0] up, input logic [NF-1:0] dn);
        hall_up_req = up;
        hall_dn_req = dn;
        tick();
        hall_up_req = '0;
        hall_dn_req = '0;
        for (int f = 0; f < NF; f++) begin
            if (up[f] && f != NF-1) m_pend[f] = 1'b1;
            if (dn[f] && f != 0)    m_pend[NF+f] = 1'b1;
        end
    endtask

    task automatic do_reset();
        rst = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        tick();
        model_clear();
    endtask

    task automatic wait_offer(output int lat);
        lat = 0;
        while (assign_valid == '0 && lat < 12) begin
            tick();
            lat++;
        end
    endtask

    task automatic serve_one(input int delay, input logic [NL-1:0] noise);
        int e, fl, k, lat;
        logic [NL-1:0] exp_v;
        logic exp_dir;
        e = model_first();
        if (e < NF) begin fl = e;      exp_dir = 1'b1; end
        else        begin fl = e - NF; exp_dir = 1'b0; end
        k = model_lift(fl);
        exp_v = 4'(1) << k;
        wait_offer(lat);
        check("latency", 32'(lat), 32'd3);
        check("lift", 32'(assign_valid), 32'(exp_v));
        check("floor", 32'(assign_floor), 32'(fl));
        check("dir", 32'(assign_dir), 32'(exp_dir));
        for (int d = 0; d < delay; d++) begin
            assign_ready = noise & ~exp_v;
            tick();
            check("hold", 32'(assign_valid), 32'(exp_v));
        end
        assign_ready = exp_v;
        tick();
        assign_ready = '0;
        check("release", 32'(assign_valid), 32'd0);
        m_pend[e] = 1'b0;
        m_ptr = (e + 1) % (2*NF);
        check("pending", 32'({dn_pending, up_pending}), model_vec());
    endtask

    initial begin
        int cnt;
        logic [NF-1:0] up, dn;
        rst = 1'b0;
        hall_up_req = '1;
        hall_dn_req = '0;
        assign_ready = '0;
        lift_busy = '1;
        lift_dir = '0;
        set_floors(0, 5, 9, 3);
        model_clear();

        // Reset holds everything clear even with requests asserted.
        tick(); tick(); tick();
        check("rst_up", 32'(up_pending), 32'd0);
        check("rst_dn", 32'(dn_pending), 32'd0);
        check("rst_valid", 32'(assign_valid), 32'd0);
        rst = 1'b1;
        tick();
        check("top_up_ignored", 32'(up_pending), 32'h3FF);
        tick(); tick(); tick();
        check("busy_no_offer", 32'(assign_valid), 32'd0);
        hall_up_req = '0;
        do_reset();
        check("pending_clear", 32'({dn_pending, up_pending}), 32'd0);

        // Nearest pick: lifts 0,5,9,3, down call at 6.
        lift_busy = '0;
        set_floors(0, 5, 9, 3);
        pulse('0, 11'(1 << 6));
        serve_one(0, '0);

        // Tie between lifts 0 and 2 with lift 1 busy.
        set_floors(2, 6, 6, 8);
        lift_busy = 4'b0010;
        pulse(11'(1 << 4), '0);
        serve_one(2, 4'b0110);

        // Round-robin from pointer 0, then a wrap past the top of the call list.
        do_reset();
        lift_busy = '0;
        set_floors(0, 5, 9, 3);
        pulse(11'((1 << 1) | (1 << 7)), 11'(1 << 3));
        serve_one(0, '0);
        serve_one(0, '0);
        serve_one(0, '0);
        pulse(11'(1), 11'(1 << 10));
        serve_one(0, '0);
        serve_one(0, '0);

        // Timeout: lift 3 never answers, lift 0 gets the same call.
        pulse(11'(1 << 2), '0);
        wait_offer(cnt);
        check("tmo_latency", 32'(cnt), 32'd3);
        check("tmo_first", 32'(assign_valid), 32'b1000);
        cnt = 0;
        while (assign_valid == 4'b1000 && cnt < 40) begin
            cnt++;
            tick();
        end
        check("tmo_len", 32'(cnt), 32'd15);
        check("tmo_drop", 32'(assign_valid), 32'd0);
        tick();
        check("tmo_reoffer", 32'(assign_valid), 32'b0001);
        check("tmo_floor", 32'(assign_floor), 32'd2);
        check("tmo_dir", 32'(assign_dir), 32'd1);
        assign_ready = 4'b0001;
        tick();
        assign_ready = '0;
        m_pend[2] = 1'b0;
        m_ptr = 3;
        check("tmo_pending", 32'({dn_pending, up_pending}), model_vec());

        // Starvation with every lift busy, then lift 3 freed.
        lift_busy = '1;
        pulse('0, 11'(1 << 5));
        for (int i = 0; i < 8; i++) begin
            tick();
            check("starve", 32'(assign_valid), 32'd0);
        end
        lift_busy = 4'b0111;
        tick();
        check("recover", 32'(assign_valid), 32'b1000);
        check("recover_floor", 32'(assign_floor), 32'd5);
        rst = 1'b0;
        #1;
        check("midrst_valid", 32'(assign_valid), 32'd0);
        check("midrst_pend", 32'(dn_pending), 32'd0);
        tick();
        rst = 1'b1;
        tick();
        model_clear();

        // Randomized floors, busy masks and call bursts.
        for (int it = 0; it < 25; it++) begin
            int g;
            for (int k = 0; k < NL; k++) begin
                if ($urandom_range(0, 4) == 0) lift_floor[k*FW +: FW] = FW'($urandom_range(11, 15));
                else                           lift_floor[k*FW +: FW] = FW'($urandom_range(0, 10));
            end
            lift_busy = NL'($urandom);
            g = int'($urandom_range(0, NL-1));
            lift_busy[g] = 1'b0;
            lift_floor[g*FW +: FW] = FW'($urandom_range(0, 10));
            up = NF'($urandom & $urandom & $urandom);
            dn = NF'($urandom & $urandom & $urandom);
            if (up == '0 && dn == '0) up[it % 10] = 1'b1;
            pulse(up, dn);
            check("rnd_latch", 32'({dn_pending, up_pending}), model_vec());
            while (model_first() >= 0) serve_one(int'($urandom_range(0, 4)), NL'($urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/hall_call_dispatcher.md
Name: hall_call_dispatcher

Overview:
- Central scheduler between the floor call buttons and the four lift controllers.
- Latches up/down hall calls from every floor and picks one pending call at a time, round-robin.
- Assigns that call to the nearest free lift over a per-lift valid/ready handshake.
- Clears the call once a lift accepts it. It sequences the shared lift resource; it does not move lifts.

Parameters:
- NUM_FLOORS, 11, number of floors (floor 0 .. NUM_FLOORS-1)
- NUM_LIFTS, 4, number of lift controllers
- FLOOR_W, 4, floor index width; must satisfy 2^FLOOR_W >= NUM_FLOORS
- ACK_TIMEOUT, 15, cycles to wait for assign_ready before re-dispatching

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-low reset
- hall_up_req  in  NUM_FLOORS  bit f high sets a pending up call at floor f
- hall_dn_req  in  NUM_FLOORS  bit f high sets a pending down call at floor f
- lift_floor  in  NUM_LIFTS*FLOOR_W  current floor of lift k in slice [k*FLOOR_W +: FLOOR_W]
- lift_busy  in  NUM_LIFTS  lift k is not available for a new assignment
- assign_valid  out  NUM_LIFTS  one-hot; offers the current call to lift k
- assign_floor  out  FLOOR_W  target floor of the offered call
- assign_dir  out  1  direction of the offered call: 1 = up, 0 = down
- assign_ready  in  NUM_LIFTS  lift k accepts the offer
- up_pending  out  NUM_FLOORS  latched up calls, for button lamps
- dn_pending  out  NUM_FLOORS  latched down calls, for button lamps

Behaviour:
- Reset, asynchronous, rst low:
  - pending regs cleared; FSM to IDLE; scan pointer 0; skip mask 0
  - assign_valid 0, assign_floor 0, assign_dir 0, timeout counter 0
  - This applies mid-handshake too: the offer is withdrawn and calls are lost.
- Pending regs:
  - Set by the request bit on a clock edge.
  - Cleared on handshake, i.e. (assign_valid[k] & assign_ready[k]) for the latched floor/dir.
  - Set and clear on the same entry in the same cycle: clear wins.
  - Up call at top floor and down call at floor 0 are ignored and never latched.
- Call index: entries 0..NUM_FLOORS-1 are up calls; NUM_FLOORS..2*NUM_FLOORS-1 are down calls.
- FSM states IDLE, SCAN, EVAL, ISSUE:
  - IDLE: any pending -> SCAN.
  - SCAN (1 cycle): latch the first pending entry at or after the scan pointer, wrapping; -> EVAL. If the latched entry is no longer pending, -> IDLE.
  - EVAL (1 cycle per attempt):
    - Candidates are lifts with !lift_busy, not in the skip mask, and lift_floor < NUM_FLOORS.
    - Cost = |lift_floor - target|, unsigned FLOOR_W+1 arithmetic.
    - Pick minimum cost; ties go to the lowest lift index.
    - No candidate: stay in EVAL and re-evaluate every cycle; the skip mask is cleared after one empty pass.
    - Candidate found: register the one-hot lift; -> ISSUE.
  - ISSUE:
    - assign_valid one-hot held stable, with assign_floor/assign_dir, until assign_ready of that lift.
    - On handshake: clear pending; scan pointer = entry+1 mod 2*NUM_FLOORS; skip mask cleared; -> IDLE.
    - Ready of a non-selected lift is ignored.
    - ACK_TIMEOUT cycles without handshake: deassert valid, set skip bit for that lift, -> EVAL.
- Latency: request latched at edge N -> assign_valid high after edge N+3 when a free lift exists.
- One outstanding offer at a time; the pointer advances only on acceptance, which gives fairness.

Optional Feature:
- Macro: DIR_AWARE_EN.
- Defined:
  - Adds input lift_dir, NUM_LIFTS*2 bits per lift: 00 idle, 01 up, 10 down.
  - Busy lifts moving toward the target in the call's direction (up and lift_floor < target, or down and lift_floor > target) also become candidates.
  - Idle or same-direction lifts get cost unchanged; other candidates are not eligible.
- Undefined: no lift_dir port; only non-busy lifts are candidates; behaviour exactly as above.

Decomposition:
- Package elevator_pkg:
  - FLOOR_W, NUM_FLOORS, NUM_LIFTS constants
  - dir_t (DIR_DN=0, DIR_UP=1); lift_dir_t (IDLE/UP/DN)
  - dispatch_state_t enum (IDLE, SCAN, EVAL, ISSUE)
- Sub-module: nearest_lift_select, a combinational min-cost/lowest-index selector. It takes the floor vector, the eligibility mask and the target, and returns a one-hot pick plus a found flag.

Test Plan:
- Reset:
  - Stimulus: hold rst low with hall_up_req=all ones.
  - Required: pending stays 0 and assign_valid 0. After release, floor 10 up is never latched.
- Nearest pick:
  - Stimulus: lifts at 0,5,9,3, all free; hall_dn_req[6] pulse.
  - Required: assign_valid=0010, assign_floor=6, dir=0 exactly 3 cycles after latch. On ready, dn_pending[6]=0.
- Tie and busy:
  - Stimulus: lifts at 2,6,6,8, lift1 busy; hall_up_req[4].
  - Required: lifts 0 and 2 both cost 2; lift 0 is chosen (assign_valid=0001).
- Round-robin:
  - Stimulus: up calls at floors 1 and 7 plus down call at 3, set together; accept each immediately.
  - Required: service order is up1, up7, dn3, and the pointer wraps to entry 0.
- Timeout:
  - Stimulus: selected lift never asserts ready.
  - Required: after 15 cycles valid drops and the next-nearest lift is offered the same call.
- Starvation, then recovery:
  - Stimulus: all lifts busy with a call pending.
  - Required: FSM stays in EVAL with valid=0. When lift 3 is freed, the offer goes to 1000 the next cycle.
